// File: rtl/instruction_fetcher.sv
// Instruction fetch unit: serves the decoder from a direct-mapped flop cache and
// falls back to a single-outstanding program-memory read on a miss.
module instruction_fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  localparam int unsigned IdxBits = $clog2(CACHE_LINES);
  // A fully-indexed cache has no tag; keep a 1-bit tag that is always zero.
  localparam int unsigned TagBits =
      (PROGRAM_MEM_ADDR_BITS > IdxBits) ? (PROGRAM_MEM_ADDR_BITS - IdxBits) : 1;

  localparam logic [2:0] CoreFetch  = 3'b001;
  localparam logic [2:0] CoreDecode = 3'b010;

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StFetching = 3'b001,
    StFetched  = 3'b010
  } state_e;

  state_e                           state_q;
  logic [CACHE_LINES-1:0]           line_valid_q;
  logic [TagBits-1:0]               line_tag_q  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data_q [CACHE_LINES];

  logic [IdxBits-1:0] lookup_idx;
  logic [TagBits-1:0] lookup_tag;
  logic [IdxBits-1:0] fill_idx;
  logic [TagBits-1:0] fill_tag;
  logic               lookup_hit;
  logic               fill_en;

  always_comb begin
    lookup_idx = current_pc[IdxBits-1:0];
    lookup_tag = TagBits'(current_pc >> IdxBits);
    // Fills use the latched request address; current_pc may move while waiting.
    fill_idx   = mem_read_address[IdxBits-1:0];
    fill_tag   = TagBits'(mem_read_address >> IdxBits);
    lookup_hit = line_valid_q[lookup_idx] && (line_tag_q[lookup_idx] == lookup_tag);
    fill_en    = (state_q == StFetching) && mem_read_ready;
  end

  assign fetcher_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (core_state == CoreFetch) begin
            if (lookup_hit) begin
              instruction <= line_data_q[lookup_idx];
              state_q     <= StFetched;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              state_q          <= StFetching;
            end
          end
        end
        StFetching: begin
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            state_q        <= StFetched;
          end
        end
        StFetched: begin
          if (core_state == CoreDecode) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q        <= StIdle;
          mem_read_valid <= 1'b0;
        end
      endcase
    end
  end

  // Flush wins over a coincident fill so a reloaded program never sees a stale line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_valid_q <= '0;
    end else if (cache_flush) begin
      line_valid_q <= '0;
    end else if (fill_en) begin
      line_valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_tag_q[fill_idx]  <= fill_tag;
      line_data_q[fill_idx] <= mem_read_data;
    end
  end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Per-core instruction fetch unit: the producer side of the `instruction` word consumed by the core's decoder. When the core scheduler enters FETCH, the unit returns the 16-bit instruction at `current_pc`. It serves hits from a small direct-mapped instruction cache and misses over the program-memory read handshake. It holds the word stable through DECODE and reports progress to the scheduler via `fetcher_state`.

## Interface
- `PROGRAM_MEM_ADDR_BITS`, default 8: PC / program-memory address width.
- `PROGRAM_MEM_DATA_BITS`, default 16: instruction width.
- `CACHE_LINES`, default 8: direct-mapped lines; power of two, 2..(2^ADDR_BITS).

Ports:
- `clk`  input  1  core clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `core_state`  input  3  scheduler state; FETCH = 3'b001, DECODE = 3'b010, others ignored.
- `current_pc`  input  ADDR_BITS  address to fetch; sampled in IDLE when core_state = FETCH.
- `cache_flush`  input  1  clears all cache valid bits (program reload).
- `mem_read_valid`  output  1  program-memory read request.
- `mem_read_address`  output  ADDR_BITS  request address.
- `mem_read_ready`  input  1  memory response valid; `mem_read_data` valid in that cycle.
- `mem_read_data`  input  DATA_BITS  returned instruction.
- `fetcher_state`  output  3  IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010.
- `instruction`  output  DATA_BITS  fetched instruction word, registered.

## Operation
- Cache: `CACHE_LINES` entries of {valid, tag, data}.
  - index = `current_pc[IDX-1:0]`, where IDX = log2(CACHE_LINES).
  - tag = `current_pc[ADDR_BITS-1:IDX]`.
  - All storage is flops. No replacement policy: a fill overwrites its indexed line.
- IDLE, with core_state = FETCH:
  - Hit (valid and tag match): `instruction` <= line data; go to FETCHED. No memory request.
  - Miss: `mem_read_valid` <= 1, `mem_read_address` <= `current_pc`; go to FETCHING.
- IDLE, with any other core_state: no action; `instruction` holds its last value.
- FETCHING:
  - `mem_read_valid` and `mem_read_address` stay stable until `mem_read_ready` is sampled high.
  - In that cycle: `instruction` <= `mem_read_data`; line written with valid = 1 and the tag; `mem_read_valid` <= 0; go to FETCHED.
  - `core_state` changes are ignored while FETCHING.
- FETCHED:
  - `instruction` holds.
  - On core_state = DECODE, go to IDLE.
  - core_state = FETCH while FETCHED does not trigger a refetch.
- `mem_read_ready` while `mem_read_valid` = 0 is ignored.
- `cache_flush`:
  - Clears every valid bit at the next edge, in any state.
  - If it coincides with a fill, the fill still updates `instruction` and the FSM, but the line is left invalid.
  - If it coincides with an IDLE lookup, the lookup uses pre-flush contents.
- Aliasing: PCs differing only in tag bits share a line; each miss evicts the previous occupant.
- PC wrap (`current_pc` = 2^ADDR_BITS - 1 followed by 0) needs no special handling.

## Timing
- Reset (reset = 0, asynchronous):
  - fetcher_state = IDLE.
  - `mem_read_valid` = 0, `mem_read_address` = 0, `instruction` = 0.
  - All valid bits cleared.
  - Applies immediately, including mid-FETCHING; the request is dropped. The memory controller shares this reset.
- Deassertion takes effect at the first rising edge with reset = 1.
- Hit latency: core_state = FETCH sampled at edge N; FETCHED and valid `instruction` visible after edge N (1 cycle).
- Miss latency:
  - `mem_read_valid` is visible after edge N.
  - `mem_read_ready` is sampled at edge M > N; FETCHED after edge M.
  - Minimum 2 cycles.
- `instruction` is stable from entry to FETCHED until the next fill or hit completes, so it is valid throughout DECODE.
- One outstanding request maximum.

## Test plan
- Cold miss:
  - Stimulus: after reset, pc = 0x03, FETCH; memory returns 0x3123 two cycles after valid.
  - Response: valid high with address 0x03 until ready; `instruction` = 0x3123; state FETCHED; valid drops the same edge.
- Hit:
  - Stimulus: DECODE, then pc = 0x03 FETCH again.
  - Response: FETCHED one cycle later with 0x3123; `mem_read_valid` never asserted.
- Alias eviction:
  - Stimulus: CACHE_LINES = 8; fetch 0x03 (0x3123), then 0x0B (0x9A05), then 0x03.
  - Response: all three are misses; the final `instruction` = 0x3123 is read from memory.
- Flush coincident with fill:
  - Stimulus: `cache_flush` in the same cycle as `mem_read_ready` for pc 0x10 (0xF000); then refetch 0x10.
  - Response: `instruction` = 0xF000; the refetch misses.
- Reset mid-fetch:
  - Stimulus: drive reset = 0 while FETCHING at pc 0x20.
  - Response: `mem_read_valid` = 0 and state IDLE immediately, with no edge needed; a late `mem_read_ready` is ignored; a subsequent fetch of 0x20 misses.
- Stall and ignore:
  - Stimulus: hold `mem_read_ready` low 10 cycles while toggling core_state; pulse ready while idle.
  - Response: address and valid stay stable, state stays FETCHING; the idle pulse changes nothing.
